periph_bus_arbiter: RTL and testbench

Shares the single peripheral bus (addr/data/read/write/ready, the bus the 7-segment display and other register-mapped peripherals sit on) between two requesters: m0 (CPU load/store unit) and m1 (debug/DMA port). Round-robin arbitration, one transaction at a time. The block latches the winning request, drives the bus strobes until `p_ready`, and returns read data with a one-cycle ack. With the optional feature compiled in, a bus timeout guards against a peripheral that never answers.

---
 rtl/periph_bus_arbiter_pkg.sv | 23 ++
 rtl/periph_bus_arbiter_rr_arbiter2.sv | 24 ++
 rtl/periph_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/periph_bus_arbiter_pkg.sv
// periph_bus_arbiter shared types and constants.
// Default widths come from `PERIPH_DATA_WIDTH / `PERIPH_ADDR_WIDTH.
`ifndef PERIPH_DATA_WIDTH
`define PERIPH_DATA_WIDTH 32
`endif
`ifndef PERIPH_ADDR_WIDTH
`define PERIPH_ADDR_WIDTH 8
`endif

package periph_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    PARB_IDLE   = 2'd0,
    PARB_ACCESS = 2'd1,
    PARB_DONE   = 2'd2
  } parb_state_e;

  localparam int PARB_TIMEOUT_DEFAULT = 16;

  localparam logic PARB_M0 = 1'b0;
  localparam logic PARB_M1 = 1'b1;

endpackage

// File: rtl/periph_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: when both request,
// the master that did not win last time goes.
module periph_bus_arbiter_rr_arbiter2
  import periph_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       gnt_o
);

  assign any_o = |req_i;

  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = PARB_M1;
    end else begin
      gnt_o = PARB_M0;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Peripheral bus arbiter: two masters, round-robin, one access at a time.
// Define PERIPH_ARB_TIMEOUT_EN to abort accesses the peripheral never answers.
`ifndef PERIPH_DATA_WIDTH
`define PERIPH_DATA_WIDTH 32
`endif
`ifndef PERIPH_ADDR_WIDTH
`define PERIPH_ADDR_WIDTH 8
`endif

module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = `PERIPH_DATA_WIDTH,
  parameter int ADDR_WIDTH = `PERIPH_ADDR_WIDTH
`ifdef PERIPH_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = PARB_TIMEOUT_DEFAULT
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [ADDR_WIDTH-1:0] p_addr,
  output logic [DATA_WIDTH-1:0] p_wdata,
  output logic                  p_data_oe,
  input  logic [DATA_WIDTH-1:0] p_rdata,
  output logic                  p_read,
  output logic                  p_write,
  input  logic                  p_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  parb_state_e state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, we_q, we_d;
  logic rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic terr_q, terr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic any, pick, fin, tmo;
  logic [DATA_WIDTH-1:0] rsel;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  periph_bus_arbiter_rr_arbiter2 u_rr (
    .req_i  ({m1_req, m0_req}),
    .last_i (last_q),
    .any_o  (any),
    .gnt_o  (pick)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    fin      = 1'b0;
    tmo      = 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      PARB_IDLE: begin
        if (any) begin
          state_d = PARB_ACCESS;
          gnt_d   = pick;
          we_d    = pick ? m1_we : m0_we;
          addr_d  = pick ? m1_addr : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          rd_d    = ~we_d;
          wr_d    = we_d;
`ifdef PERIPH_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      PARB_ACCESS: begin
        rd_d = ~we_q;
        wr_d = we_q;
        if (p_ready) begin
          fin = 1'b1;
`ifdef PERIPH_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          fin = 1'b1;
          tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
        if (fin) begin
          state_d = PARB_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack0_d  = (gnt_q == PARB_M0);
          ack1_d  = (gnt_q == PARB_M1);
          if (!we_q) begin
            if (gnt_q == PARB_M1) rdata1_d = rsel;
            else                  rdata0_d = rsel;
          end
        end
      end
      PARB_DONE: begin
        state_d = PARB_IDLE;
        last_d  = gnt_q;
      end
      default: state_d = PARB_IDLE;
    endcase
    terr_d = tmo;
    busy_d = (state_d != PARB_IDLE);
  end

  // Aborted reads return all-ones so software sees a recognisable value.
  assign rsel = tmo ? '1 : p_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PARB_IDLE;
      gnt_q    <= PARB_M0;
      last_q   <= PARB_M1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      terr_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      terr_q   <= terr_d;
      busy_q   <= busy_d;
`ifdef PERIPH_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign p_addr      = addr_q;
  assign p_wdata     = wdata_q;
  assign p_read      = rd_q;
  assign p_write     = wr_q;
  assign p_data_oe   = wr_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomised bench for periph_bus_arbiter against a
// transaction-timing reference model.
module tb_periph_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NCYC = 4000;
`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int TO = 4;
  localparam int WMAX = 6;
`else
  localparam int WMAX = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, p_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [DW-1:0] p_wdata, p_rdata;
  logic m0_ack, m1_ack, p_data_oe, p_read, p_write;
  logic p_ready, busy, timeout_err;

  always #5 clk = ~clk;

  periph_bus_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
`ifdef PERIPH_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk (clk), .rst (rst),
    .m0_req (m0_req), .m0_we (m0_we), .m0_addr (m0_addr),
    .m0_wdata (m0_wdata), .m0_rdata (m0_rdata), .m0_ack (m0_ack),
    .m1_req (m1_req), .m1_we (m1_we), .m1_addr (m1_addr),
    .m1_wdata (m1_wdata), .m1_rdata (m1_rdata), .m1_ack (m1_ack),
    .p_addr (p_addr), .p_wdata (p_wdata), .p_data_oe (p_data_oe),
    .p_rdata (p_rdata), .p_read (p_read), .p_write (p_write),
    .p_ready (p_ready), .busy (busy), .timeout_err (timeout_err)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
  endtask

  // Peripheral register file
  logic [DW-1:0] mem [0:255];

  // Reference model: one transaction described by its cycle times
  bit            in_txn;
  bit            t_g, t_we, t_to, last;
  logic [AW-1:0] t_addr, e_addr;
  logic [DW-1:0] t_wdata, e_wdata;
  logic [DW-1:0] e_rd [2];
  int            s_cyc, end_cyc, ready_cyc, ack_cyc, w;

  // Requester agents
  bit            a_req [2], a_we [2], a_drop [2];
  logic [AW-1:0] a_addr [2];
  logic [DW-1:0] a_wd [2];
  int            a_gap [2];
  bit            ack_cur [2], ack_prev [2];

  initial begin
    bit stb, ack;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    in_txn = 0;
    last = 1;
    for (int i = 0; i < 2; i++) begin
      a_req[i] = 0; a_drop[i] = 0; a_gap[i] = 0;
      ack_cur[i] = 0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      stb = in_txn && cyc >= s_cyc && cyc <= end_cyc;
      ack = in_txn && cyc == ack_cyc;
      ack_prev = ack_cur;
      ack_cur[0] = ack && !t_g;
      ack_cur[1] = ack && t_g;
      if (cyc > 0) begin
        chk("p_read", p_read, stb && !t_we);
        chk("p_write", p_write, stb && t_we);
        chk("p_data_oe", p_data_oe, stb && t_we);
        chk("busy", busy, in_txn);
        chk("m0_ack", m0_ack, ack_cur[0]);
        chk("m1_ack", m1_ack, ack_cur[1]);
        chk("timeout_err", timeout_err, ack && t_to);
        chk("p_addr", p_addr, e_addr);
        chk("p_wdata", p_wdata, e_wdata);
        chk("m0_rdata", m0_rdata, e_rd[0]);
        chk("m1_rdata", m1_rdata, e_rd[1]);
      end
      for (int i = 0; i < 2; i++) begin
        if (ack_prev[i]) begin
          a_req[i] = 0;
          a_drop[i] = 0;
          a_gap[i] = $urandom_range(0, 3);
        end else if (!a_req[i] && !a_drop[i]) begin
          if (a_gap[i] > 0) a_gap[i]--;
          else begin
            a_req[i] = 1;
            a_we[i] = 1'($urandom);
            a_addr[i] = AW'($urandom);
            a_wd[i] = $urandom;
          end
        end else if (a_req[i] && in_txn && int'(t_g) == i &&
                     cyc > s_cyc && $urandom_range(0, 7) == 0) begin
          a_req[i] = 0;
          a_drop[i] = 1;
        end
        if (!a_req[i]) begin
          a_we[i] = 1'($urandom);
          a_addr[i] = AW'($urandom);
          a_wd[i] = $urandom;
        end
      end
      rst = (cyc < 3) || ($urandom_range(0, 299) == 0);
      m0_req = a_req[0]; m0_we = a_we[0];
      m0_addr = a_addr[0]; m0_wdata = a_wd[0];
      m1_req = a_req[1]; m1_we = a_we[1];
      m1_addr = a_addr[1]; m1_wdata = a_wd[1];
      p_ready = stb && cyc == ready_cyc;
      p_rdata = stb ? mem[t_addr] : $urandom;

      @(posedge clk);
      if (rst) begin
        in_txn = 0;
        last = 1;
        e_rd[0] = '0; e_rd[1] = '0;
        e_addr = '0; e_wdata = '0;
        for (int i = 0; i < 2; i++) begin
          a_req[i] = 0; a_drop[i] = 0; a_gap[i] = 0;
        end
      end else if (in_txn) begin
        if (cyc == end_cyc) begin
          if (t_to) begin
            if (!t_we) e_rd[t_g] = '1;
          end else if (t_we) mem[t_addr] = t_wdata;
          else e_rd[t_g] = mem[t_addr];
        end
        if (cyc == ack_cyc) begin
          last = t_g;
          in_txn = 0;
        end
      end else if (a_req[0] || a_req[1]) begin
        t_g = (a_req[0] && a_req[1]) ? !last : a_req[1];
        t_we = a_we[t_g];
        t_addr = a_addr[t_g];
        t_wdata = a_wd[t_g];
        e_addr = t_addr;
        e_wdata = t_wdata;
        in_txn = 1;
        w = $urandom_range(0, WMAX);
        s_cyc = cyc + 1;
        ready_cyc = s_cyc + w;
`ifdef PERIPH_ARB_TIMEOUT_EN
        t_to = (w >= TO);
        end_cyc = s_cyc + (t_to ? TO - 1 : w);
`else
        t_to = 0;
        end_cyc = ready_cyc;
`endif
        ack_cyc = end_cyc + 1;
      end
      #1;
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
